pads_cfg_seq: RTL and testbench

Wishbone master sequencer that programs the per-pad output-enable registers of the pad configuration block (`BASE_ADDR`, one register per pad at byte offset = pad index) from a single direction mask. It keeps a shadow of the last committed mask and writes only the pads that differ. Each write can optionally be verified by read-back, and every transaction is bounded by an ack timeout. It sits between the management/boot logic and the pad configuration slave, so firmware does not have to issue 38 individual writes.

---
 rtl/pads_cfg_pkg.sv | 29 ++
 rtl/pads_cfg_wb_xfer.sv | 85 ++++++++
 rtl/pads_cfg_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_pads_cfg_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pads_cfg_pkg.sv
// Shared definitions for the pad output-enable sequencer: sequencer states,
// default slave base address and pad count, error-code encodings and a
// helper that forms the slave address of a pad.
package pads_cfg_pkg;

  localparam logic [31:0] PADS_CFG_BASE = 32'h3000_6000;
  localparam int          PADS_CFG_NUM  = 38;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_VERIFY  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_WR     = 3'd2,
    ST_WR_GAP = 3'd3,
    ST_RD     = 3'd4,
    ST_RD_GAP = 3'd5,
    ST_FIN    = 3'd6,
    ST_FAIL   = 3'd7
  } state_t;

  // One register per pad, byte-addressed from the base.
  function automatic logic [31:0] pad_addr(input logic [31:0] base, input logic [7:0] idx);
    return base + {24'h00_0000, idx};
  endfunction

endpackage

// File: rtl/pads_cfg_wb_xfer.sv
// Single Wishbone transaction engine.
// Ports: i_start (one-cycle request, accepted only while the bus is idle),
// i_we/i_adr/i_dat (transaction attributes), o_done (ack seen this cycle),
// o_timeout (no ack within ACK_TIMEOUT cycles), o_rdata (read data, valid
// with o_done), o_cyc/o_stb/o_we/o_sel/o_adr/o_dat (registered bus outputs),
// i_ack/i_rdat (slave response).
// A new request can only be accepted once the previous one has ended, so the
// cycle after each completion is always an idle bus cycle.
module pads_cfg_wb_xfer
  import pads_cfg_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        i_start,
  input  logic        i_we,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_dat,
  output logic        o_done,
  output logic        o_timeout,
  output logic [31:0] o_rdata,
  output logic        o_cyc,
  output logic        o_stb,
  output logic        o_we,
  output logic [3:0]  o_sel,
  output logic [31:0] o_adr,
  output logic [31:0] o_dat,
  input  logic        i_ack,
  input  logic [31:0] i_rdat
);

  // Last wait cycle: the counter would reach ACK_TIMEOUT at the next edge.
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  logic        r_act;
  logic        r_we;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [7:0]  r_cnt;

  logic w_accept;
  logic w_ack_ok;
  logic w_tmo;

  assign w_accept  = i_start & ~r_act;
  assign w_ack_ok  = r_act & i_ack;
  // Ack wins over a timeout that would fire in the same cycle.
  assign w_tmo     = r_act & ~i_ack & (r_cnt == TMO_LAST);

  assign o_done    = w_ack_ok;
  assign o_timeout = w_tmo;
  assign o_rdata   = i_rdat;
  assign o_cyc     = r_act;
  assign o_stb     = r_act;
  assign o_we      = r_we;
  assign o_sel     = 4'hF;
  assign o_adr     = r_adr;
  assign o_dat     = r_dat;

  // Bus request register, latched attributes and ack wait counter.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_act <= 1'b0;
      r_we  <= 1'b0;
      r_adr <= 32'h0000_0000;
      r_dat <= 32'h0000_0000;
      r_cnt <= 8'd0;
    end else if (w_accept) begin
      r_act <= 1'b1;
      r_we  <= i_we;
      r_adr <= i_adr;
      r_dat <= i_dat;
      r_cnt <= 8'd0;
    end else if (w_ack_ok || w_tmo) begin
      r_act <= 1'b0;
      r_we  <= 1'b0;
    end else if (r_act) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/pads_cfg_seq.sv
// Pad output-enable sequencer: commits a direction mask to the pad
// configuration slave, writing only pads whose bit differs from the shadow
// of the last committed mask (or all pads when forced / shadow invalid), with
// optional read-back verification of each write.
// Ports: clk, resetb (async active-low), start/dir_mask/force_all (request),
// busy/done/err/err_idx/err_code (status), wbm_* (Wishbone master).
module pads_cfg_seq
  import pads_cfg_pkg::*;
#(
  parameter int          NUM_PADS    = PADS_CFG_NUM,
  parameter logic [31:0] BASE_ADDR   = PADS_CFG_BASE,
  parameter int          ACK_TIMEOUT = 16,
  parameter bit          VERIFY      = 1'b1,
  parameter int          IDX_W       = $clog2(NUM_PADS)
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                start,
  input  logic [NUM_PADS-1:0] dir_mask,
  input  logic                force_all,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [IDX_W-1:0]    err_idx,
  output logic [1:0]          err_code,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [3:0]          wbm_sel_o,
  output logic [31:0]         wbm_adr_o,
  output logic [31:0]         wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [31:0]         wbm_dat_i
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_PADS-1:0] r_mask;
  logic                r_force;
  logic [NUM_PADS-1:0] r_shadow;
  logic                r_shadow_vld;
  logic [IDX_W-1:0]    r_idx;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [IDX_W-1:0]    r_err_idx;
  logic [1:0]          r_err_code;

  logic        w_mask_bit;
  logic        w_need;
  logic        w_last;
  logic        w_accept;
  logic        w_adv;
  logic        w_commit;
  logic [1:0]  w_fail_code;
  logic        w_xfer_start;
  logic        w_xfer_we;
  logic        w_xfer_done;
  logic        w_xfer_tmo;
  logic [31:0] w_rdata;
  logic        w_unused_rdata;

  assign w_mask_bit     = r_mask[r_idx];
  assign w_need         = r_force | ~r_shadow_vld | (w_mask_bit != r_shadow[r_idx]);
  assign w_last         = (r_idx == IDX_W'(NUM_PADS - 1));
  assign w_accept       = (r_state == ST_IDLE) & start;
  // Only the OEN bit of the pad register is meaningful on read-back.
  assign w_unused_rdata = ^w_rdata[31:1];

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign err_idx  = r_err_idx;
  assign err_code = r_err_code;

  pads_cfg_wb_xfer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_xfer (
    .clk       (clk),
    .resetb    (resetb),
    .i_start   (w_xfer_start),
    .i_we      (w_xfer_we),
    .i_adr     (pad_addr(BASE_ADDR, 8'(r_idx))),
    .i_dat     ({31'h0000_0000, w_mask_bit}),
    .o_done    (w_xfer_done),
    .o_timeout (w_xfer_tmo),
    .o_rdata   (w_rdata),
    .o_cyc     (wbm_cyc_o),
    .o_stb     (wbm_stb_o),
    .o_we      (wbm_we_o),
    .o_sel     (wbm_sel_o),
    .o_adr     (wbm_adr_o),
    .o_dat     (wbm_dat_o),
    .i_ack     (wbm_ack_i),
    .i_rdat    (wbm_dat_i)
  );

  // Next-state decode; transaction requests are issued one cycle ahead so the
  // registered strobe rises on the first cycle of WR/RD.
  always_comb begin
    w_state_nxt  = r_state;
    w_xfer_start = 1'b0;
    w_xfer_we    = 1'b0;
    w_adv        = 1'b0;
    w_commit     = 1'b0;
    w_fail_code  = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SCAN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (w_need) begin
          w_state_nxt  = ST_WR;
          w_xfer_start = 1'b1;
          w_xfer_we    = 1'b1;
        end else if (w_last) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_adv = 1'b1;
        end
      end
      ST_WR: begin
        if (w_xfer_done) begin
          w_state_nxt = ST_WR_GAP;
        end else if (w_xfer_tmo) begin
          w_state_nxt = ST_FAIL;
          w_fail_code = ERR_TIMEOUT;
        end else begin
          w_state_nxt = ST_WR;
        end
      end
      ST_WR_GAP: begin
        if (VERIFY) begin
          w_state_nxt  = ST_RD;
          w_xfer_start = 1'b1;
        end else begin
          w_commit = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_state_nxt = ST_SCAN;
            w_adv       = 1'b1;
          end
        end
      end
      ST_RD: begin
        if (w_xfer_done) begin
          if (w_rdata[0] == w_mask_bit) begin
            w_state_nxt = ST_RD_GAP;
          end else begin
            w_state_nxt = ST_FAIL;
            w_fail_code = ERR_VERIFY;
          end
        end else if (w_xfer_tmo) begin
          w_state_nxt = ST_FAIL;
          w_fail_code = ERR_TIMEOUT;
        end else begin
          w_state_nxt = ST_RD;
        end
      end
      ST_RD_GAP: begin
        w_commit = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_state_nxt = ST_SCAN;
          w_adv       = 1'b1;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      ST_FAIL: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus mask/shadow/index bookkeeping and registered status.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state      <= ST_IDLE;
      r_mask       <= '0;
      r_force      <= 1'b0;
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_idx    <= '0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_FIN);

      if (w_accept) begin
        r_mask     <= dir_mask;
        r_force    <= force_all;
        r_idx      <= '0;
        r_err      <= 1'b0;
        r_err_idx  <= '0;
        r_err_code <= ERR_NONE;
      end else if (w_adv) begin
        r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
      end else if (w_state_nxt == ST_FAIL) begin
        r_err      <= 1'b1;
        r_err_idx  <= r_idx;
        r_err_code <= w_fail_code;
      end else begin
        r_idx <= r_idx;
      end

      if (w_commit) begin
        r_shadow[r_idx] <= w_mask_bit;
      end else begin
        r_shadow <= r_shadow;
      end

      // A failed run leaves the slave in an unknown state: force a full rewrite.
      if (r_state == ST_FIN) begin
        r_shadow_vld <= 1'b1;
      end else if (w_state_nxt == ST_FAIL) begin
        r_shadow_vld <= 1'b0;
      end else begin
        r_shadow_vld <= r_shadow_vld;
      end
    end
  end

endmodule

// File: tb/tb_pads_cfg_seq.sv
module tb_pads_cfg_seq;
  import pads_cfg_pkg::*;

  localparam int          N    = 38;
  localparam logic [31:0] BASE = 32'h3000_6000;
  localparam int          TMO  = 16;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  dir_mask = '0;
  logic          force_all = 1'b0;
  logic          busy, done, err;
  logic [5:0]    err_idx;
  logic [1:0]    err_code;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]    wbm_sel_o;
  logic [31:0]   wbm_adr_o, wbm_dat_o;
  logic          wbm_ack_i;
  logic [31:0]   wbm_dat_i;

  int checks = 0;
  int errors = 0;

  pads_cfg_seq #(
    .NUM_PADS(N), .BASE_ADDR(BASE), .ACK_TIMEOUT(TMO), .VERIFY(1'b1)
  ) dut (
    .clk(clk), .resetb(resetb), .start(start), .dir_mask(dir_mask),
    .force_all(force_all), .busy(busy), .done(done), .err(err),
    .err_idx(err_idx), .err_code(err_code), .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  int cyc_no = 0;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  // Slave: ack in the cycle after the strobe is seen, optional faults.
  logic slv_mem [N];
  int   nack_pad = -1;
  int   bad_rd_pad = -1;
  int   slv_p;
  assign slv_p = int'(wbm_adr_o - BASE);

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wbm_ack_i <= 1'b0;
      wbm_dat_i <= 32'h0;
    end else begin
      wbm_ack_i <= 1'b0;
      if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && slv_p >= 0 && slv_p < N && slv_p != nack_pad) begin
        wbm_ack_i <= 1'b1;
        wbm_dat_i <= {31'h0, (slv_p == bad_rd_pad) ? 1'b0 : slv_mem[slv_p]};
      end
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && wbm_we_o && slv_p >= 0 && slv_p < N)
        slv_mem[slv_p] <= wbm_dat_o[0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: shadow of the committed mask and expected bus traffic.
  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          len;
  } txn_t;

  txn_t         exp_q[$];
  logic [N-1:0] m_shadow = '0;
  bit           m_vld = 1'b0;

  task automatic model_run(input logic [N-1:0] mask, input bit frc, input int to_pad,
                           input int vf_pad, output bit ok, output int fidx,
                           output logic [1:0] fcode, output int fin);
    int   c;
    bit   need;
    txn_t t;
    ok = 1'b1; fidx = 0; fcode = 2'b00; c = 0; fin = 0;
    for (int i = 0; i < N; i++) begin
      c = c + 1;  // one scan cycle per pad
      need = frc || !m_vld || (mask[i] != m_shadow[i]);
      if (need) begin
        t.we = 1'b1; t.adr = BASE + 32'(i); t.dat = {31'h0, mask[i]};
        t.len = (i == to_pad) ? TMO : 2;
        exp_q.push_back(t);
        if (i == to_pad) begin ok = 1'b0; fidx = i; fcode = 2'b01; break; end
        t.we = 1'b0; t.len = 2;
        exp_q.push_back(t);
        if (i == vf_pad && mask[i]) begin ok = 1'b0; fidx = i; fcode = 2'b10; break; end
        c = c + 6;  // WR 2 + gap 1 + RD 2 + gap 1
        m_shadow[i] = mask[i];
      end
    end
    if (ok) begin m_vld = 1'b1; fin = c + 1; end
    else m_vld = 1'b0;
  endtask

  // Compare process: every bus transaction against the expected queue.
  bit          prev_cyc = 1'b0;
  int          cur_len = 0;
  txn_t        cur;
  int          txn_seen = 0;
  logic [31:0] first_adr, first_dat;
  int          done_cnt = 0;
  int          done_rel = -1;
  int          start_cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!resetb) begin
        prev_cyc = 1'b0;
        cur_len = 0;
      end else begin
        if (wbm_cyc_o && !prev_cyc) begin
          txn_seen++;
          if (txn_seen == 1) begin first_adr = wbm_adr_o; first_dat = wbm_dat_o; end
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_txn actual adr=%h we=%0d required no transaction", wbm_adr_o, wbm_we_o);
            cur.len = 0;
          end else begin
            cur = exp_q.pop_front();
            chk("txn_we", 32'(wbm_we_o), 32'(cur.we));
            chk("txn_adr", wbm_adr_o, cur.adr);
            if (cur.we) chk("txn_dat", wbm_dat_o, cur.dat);
          end
          cur_len = 0;
        end
        if (wbm_cyc_o) begin
          cur_len++;
          chk("stb_eq_cyc", 32'(wbm_stb_o), 32'd1);
          chk("sel", 32'(wbm_sel_o), 32'hF);
        end
        if (!wbm_cyc_o && prev_cyc) chk("txn_len", 32'(cur_len), 32'(cur.len));
        prev_cyc = wbm_cyc_o;
        if (done) begin done_cnt++; done_rel = cyc_no - start_cyc; end
      end
    end
  end

  task automatic do_run(input logic [N-1:0] mask, input bit frc, input int to_pad,
                        input int vf_pad, input int extra_at, input int rst_pad);
    bit         ok;
    int         fidx, fin, n;
    logic [1:0] fcode;
    bit         aborted;
    nack_pad = to_pad;
    bad_rd_pad = vf_pad;
    model_run(mask, frc, to_pad, vf_pad, ok, fidx, fcode, fin);
    @(negedge clk);
    txn_seen = 0; done_cnt = 0; done_rel = -1;
    dir_mask = mask; force_all = frc; start = 1'b1; start_cyc = cyc_no;
    @(negedge clk);
    start = 1'b0;
    chk("busy_cycle1", 32'(busy), 32'd1);
    n = 0; aborted = 1'b0;
    while (busy && n < 3000 && !aborted) begin
      if (n == extra_at) begin
        start = 1'b1; dir_mask = ~mask; force_all = 1'b1;
      end else begin
        start = 1'b0; dir_mask = mask; force_all = frc;
      end
      if (rst_pad >= 0 && wbm_cyc_o && wbm_we_o && wbm_adr_o == BASE + 32'(rst_pad)) begin
        #2 resetb = 1'b0;
        #1;
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        m_vld = 1'b0;
        aborted = 1'b1;
        repeat (2) @(negedge clk);
        resetb = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL run_bound actual=busy after %0d cycles required=idle", n);
    end
    chk("done_count", 32'(done_cnt), (ok && !aborted) ? 32'd1 : 32'd0);
    if (ok && !aborted) chk("done_cycle", 32'(done_rel), 32'(fin));
    chk("err", 32'(err), (!ok && !aborted) ? 32'd1 : 32'd0);
    if (!ok && !aborted) begin
      chk("err_code", 32'(err_code), 32'(fcode));
      chk("err_idx", 32'(err_idx), 32'(fidx));
    end
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  logic [N-1:0] mask_b5;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cyc0", 32'(wbm_cyc_o), 32'd0);
    chk("rst_stb0", 32'(wbm_stb_o), 32'd0);
    chk("rst_we0", 32'(wbm_we_o), 32'd0);
    chk("rst_sel0", 32'(wbm_sel_o), 32'hF);
    chk("rst_adr0", wbm_adr_o, 32'h0);
    chk("rst_dat0", wbm_dat_o, 32'h0);
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_done0", 32'(done), 32'd0);
    chk("rst_err0", 32'(err), 32'd0);
    chk("rst_errcode0", 32'(err_code), 32'd0);
    chk("rst_erridx0", 32'(err_idx), 32'd0);
    resetb = 1'b1;
    repeat (2) @(negedge clk);

    // Full write of all ones after reset.
    do_run({N{1'b1}}, 1'b0, -1, -1, -1, -1);
    chk("lit_run1_txns", 32'(txn_seen), 32'd76);
    chk("lit_run1_done", 32'(done_rel), 32'd267);

    // Only pad 5 changes.
    mask_b5 = {N{1'b1}};
    mask_b5[5] = 1'b0;
    do_run(mask_b5, 1'b0, -1, -1, -1, -1);
    chk("lit_run2_txns", 32'(txn_seen), 32'd2);
    chk("lit_run2_adr", first_adr, 32'h3000_6005);
    chk("lit_run2_dat", first_dat, 32'h0);
    chk("lit_run2_done", 32'(done_rel), 32'd45);

    // Nothing to write.
    do_run(mask_b5, 1'b0, -1, -1, -1, -1);
    chk("lit_run3_txns", 32'(txn_seen), 32'd0);
    chk("lit_run3_done", 32'(done_rel), 32'd39);

    // Pad 3 never acked.
    do_run(mask_b5, 1'b1, 3, -1, -1, -1);
    chk("lit_tmo_txns", 32'(txn_seen), 32'd7);
    chk("lit_tmo_code", 32'(err_code), 32'd1);
    chk("lit_tmo_idx", 32'(err_idx), 32'd3);

    // Shadow invalidated: everything rewritten.
    do_run(mask_b5, 1'b0, -1, -1, -1, -1);
    chk("lit_recover_txns", 32'(txn_seen), 32'd76);

    // Read-back of pad 7 disagrees.
    do_run(mask_b5, 1'b1, -1, 7, -1, -1);
    chk("lit_vfy_txns", 32'(txn_seen), 32'd16);
    chk("lit_vfy_code", 32'(err_code), 32'd2);
    chk("lit_vfy_idx", 32'(err_idx), 32'd7);

    // start pulsed mid-run is ignored.
    do_run(mask_b5, 1'b0, -1, -1, 20, -1);
    chk("lit_busy_start_txns", 32'(txn_seen), 32'd76);

    // Reset during the write of pad 10, then a full rewrite.
    do_run(mask_b5, 1'b1, -1, -1, -1, 10);
    do_run(mask_b5, 1'b0, -1, -1, -1, -1);
    chk("lit_after_rst_txns", 32'(txn_seen), 32'd76);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=still running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
